// File: rtl/bp_be_pipe_int_staged.sv
// Staged RV64 integer pipe: a combinational ALU in stage 0 followed by
// latency_p register stages, with stall, flush, tag pass-through and busy.
// Optional feature macro: BP_BE_PIPE_INT_ZBB_EN (min/max/minu/maxu/clz/ctz/cpop).
module bp_be_pipe_int_staged
  #(parameter int dword_width_p = 64,
    parameter int word_width_p  = 32,
    parameter int latency_p     = 2,
    parameter int tag_width_p   = 5)
  (input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic                     v_i,
   input  logic [4:0]               fu_op_i,
   input  logic                     opw_i,
   input  logic [dword_width_p-1:0] src1_i,
   input  logic [dword_width_p-1:0] src2_i,
   input  logic [tag_width_p-1:0]   tag_i,
   input  logic                     stall_i,
   input  logic                     flush_i,
   output logic                     v_o,
   output logic [dword_width_p-1:0] data_o,
   output logic [tag_width_p-1:0]   tag_o,
   output logic                     busy_o);

  localparam int shamt_w_lp  = $clog2(dword_width_p);
  localparam int wshamt_w_lp = $clog2(word_width_p);

  localparam logic [4:0] op_add  = 5'd0,  op_sub  = 5'd1,  op_xor  = 5'd2;
  localparam logic [4:0] op_or   = 5'd3,  op_and  = 5'd4,  op_sll  = 5'd5;
  localparam logic [4:0] op_srl  = 5'd6,  op_sra  = 5'd7,  op_pass = 5'd8;
  localparam logic [4:0] op_eq   = 5'd9,  op_ne   = 5'd10, op_slt  = 5'd11;
  localparam logic [4:0] op_sltu = 5'd12, op_sge  = 5'd13, op_sgeu = 5'd14;
`ifdef BP_BE_PIPE_INT_ZBB_EN
  localparam logic [4:0] op_min  = 5'd16, op_max  = 5'd17, op_minu = 5'd18;
  localparam logic [4:0] op_maxu = 5'd19, op_clz  = 5'd20, op_ctz  = 5'd21;
  localparam logic [4:0] op_cpop = 5'd22;
`endif

  function automatic logic [dword_width_p-1:0] sext_word(input logic [dword_width_p-1:0] x);
    return {{(dword_width_p-word_width_p){x[word_width_p-1]}}, x[word_width_p-1:0]};
  endfunction

  function automatic logic [dword_width_p-1:0] zext_word(input logic [dword_width_p-1:0] x);
    return {{(dword_width_p-word_width_p){1'b0}}, x[word_width_p-1:0]};
  endfunction

`ifdef BP_BE_PIPE_INT_ZBB_EN
  // Highest set bit below the limit wins; an all-zero operand yields the limit.
  function automatic logic [dword_width_p-1:0] clz_f(input logic [dword_width_p-1:0] a,
                                                     input logic word);
    int lim;
    logic [dword_width_p-1:0] cnt;
    lim = word ? word_width_p : dword_width_p;
    cnt = dword_width_p'(lim);
    for (int i = 0; i < dword_width_p; i++)
      if (i < lim && a[i]) cnt = dword_width_p'(lim - 1 - i);
    return cnt;
  endfunction

  function automatic logic [dword_width_p-1:0] ctz_f(input logic [dword_width_p-1:0] a,
                                                     input logic word);
    int lim;
    logic [dword_width_p-1:0] cnt;
    lim = word ? word_width_p : dword_width_p;
    cnt = dword_width_p'(lim);
    for (int i = dword_width_p - 1; i >= 0; i--)
      if (i < lim && a[i]) cnt = dword_width_p'(i);
    return cnt;
  endfunction

  function automatic logic [dword_width_p-1:0] cpop_f(input logic [dword_width_p-1:0] a,
                                                      input logic word);
    int lim;
    logic [dword_width_p-1:0] cnt;
    lim = word ? word_width_p : dword_width_p;
    cnt = '0;
    for (int i = 0; i < dword_width_p; i++)
      if (i < lim && a[i]) cnt = cnt + 1'b1;
    return cnt;
  endfunction
`endif

  logic [dword_width_p-1:0]        a_zx, b_zx, alu_p0, res_p0;
  logic signed [dword_width_p-1:0] a_sx, b_sx;
  logic [shamt_w_lp-1:0]           shamt_p0;

  // Stage 0: operand conditioning and combinational ALU result
  always_comb begin
    a_zx     = opw_i ? zext_word(src1_i) : src1_i;
    b_zx     = opw_i ? zext_word(src2_i) : src2_i;
    a_sx     = opw_i ? sext_word(src1_i) : src1_i;
    b_sx     = opw_i ? sext_word(src2_i) : src2_i;
    shamt_p0 = opw_i ? shamt_w_lp'(src2_i[wshamt_w_lp-1:0]) : src2_i[shamt_w_lp-1:0];
    alu_p0   = '0;
    case (fu_op_i)
      op_add:  alu_p0 = a_zx + b_zx;
      op_sub:  alu_p0 = a_zx - b_zx;
      op_xor:  alu_p0 = src1_i ^ src2_i;
      op_or:   alu_p0 = src1_i | src2_i;
      op_and:  alu_p0 = src1_i & src2_i;
      op_sll:  alu_p0 = a_zx << shamt_p0;
      op_srl:  alu_p0 = a_zx >> shamt_p0;
      op_sra:  alu_p0 = a_sx >>> shamt_p0;
      op_pass: alu_p0 = src2_i;
      op_eq:   alu_p0[0] = (a_zx == b_zx);
      op_ne:   alu_p0[0] = (a_zx != b_zx);
      op_slt:  alu_p0[0] = (a_sx < b_sx);
      op_sltu: alu_p0[0] = (a_zx < b_zx);
      op_sge:  alu_p0[0] = !(a_sx < b_sx);
      op_sgeu: alu_p0[0] = !(a_zx < b_zx);
`ifdef BP_BE_PIPE_INT_ZBB_EN
      op_min:  alu_p0 = (a_sx < b_sx) ? a_sx : b_sx;
      op_max:  alu_p0 = (a_sx < b_sx) ? b_sx : a_sx;
      op_minu: alu_p0 = (a_zx < b_zx) ? a_zx : b_zx;
      op_maxu: alu_p0 = (a_zx < b_zx) ? b_zx : a_zx;
      op_clz:  alu_p0 = clz_f(a_zx, opw_i);
      op_ctz:  alu_p0 = ctz_f(a_zx, opw_i);
      op_cpop: alu_p0 = cpop_f(a_zx, opw_i);
`endif
      default: alu_p0 = '0;
    endcase
    // Word results keep only the low word, sign-extended; 0/1 and counts are unaffected.
    res_p0 = opw_i ? sext_word(alu_p0) : alu_p0;
  end

  logic [latency_p-1:0]     stage_vld;
  logic [dword_width_p-1:0] stage_data [latency_p];
  logic [tag_width_p-1:0]   stage_tag  [latency_p];

  // Stages 1..latency_p: reset clears all, flush kills valids, stall holds everything
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      stage_vld <= '0;
      for (int k = 0; k < latency_p; k++) begin
        stage_data[k] <= '0;
        stage_tag[k]  <= '0;
      end
    end else if (flush_i) begin
      stage_vld <= '0;
    end else if (!stall_i) begin
      stage_vld[0]  <= v_i;
      stage_data[0] <= res_p0;
      stage_tag[0]  <= tag_i;
      for (int k = 1; k < latency_p; k++) begin
        stage_vld[k]  <= stage_vld[k-1];
        stage_data[k] <= stage_data[k-1];
        stage_tag[k]  <= stage_tag[k-1];
      end
    end
  end

  // Output stage: last register, with data/tag forced to zero when not valid
  always_comb begin
    v_o    = stage_vld[latency_p-1];
    data_o = v_o ? stage_data[latency_p-1] : '0;
    tag_o  = v_o ? stage_tag[latency_p-1] : '0;
    busy_o = |stage_vld;
  end

endmodule

// File: tb/tb_bp_be_pipe_int_staged.sv
// Scoreboard bench for bp_be_pipe_int_staged (latency_p=2). The driver pushes the
// hand-computed result, tag and arrival cycle for every op that should retire; a
// negedge monitor pops and compares whenever v_o is presented and accepted.
module tb_bp_be_pipe_int_staged;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        v_in = 1'b0;
  logic [4:0]  fu_op = '0;
  logic        opw = 1'b0;
  logic [63:0] src1 = '0, src2 = '0;
  logic [4:0]  tag_in = '0;
  logic        stall = 1'b0, flush = 1'b0;
  logic        v_out;
  logic [63:0] data_out;
  logic [4:0]  tag_out;
  logic        busy;

  bp_be_pipe_int_staged #(.dword_width_p(64), .word_width_p(32),
                          .latency_p(LAT), .tag_width_p(5)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v_in), .fu_op_i(fu_op), .opw_i(opw),
    .src1_i(src1), .src2_i(src2), .tag_i(tag_in), .stall_i(stall), .flush_i(flush),
    .v_o(v_out), .data_o(data_out), .tag_o(tag_out), .busy_o(busy));

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  tag;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [4:0]  op;
    logic        opw;
    logic [63:0] s1;
    logic [63:0] s2;
    logic [63:0] res;
  } vec_t;

  exp_t q[$];
  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  logic mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: an output held by stall, killed by flush, or overridden by reset is not consumed
  always @(negedge clk) begin
    if (mon_en) begin
      if (v_out && reset_n && !stall && !flush) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_output: got data 0x%016h tag %0d at cycle %0d, expected none",
                   data_out, tag_out, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (data_out !== e.data || tag_out !== e.tag || cyc != e.cyc) begin
            n_bad++;
            $display("FAIL result: got data 0x%016h tag %0d cycle %0d, expected data 0x%016h tag %0d cycle %0d",
                     data_out, tag_out, cyc, e.data, e.tag, e.cyc);
          end
        end
      end else if (!v_out) begin
        check("gated_data", data_out, 64'd0);
        check("gated_tag", {59'd0, tag_out}, 64'd0);
      end
    end
  end

  task automatic issue(input logic [4:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] t,
                       input logic [63:0] res, input logic push);
    @(posedge clk); #1;
    v_in = 1'b1; fu_op = op; opw = w; src1 = a; src2 = b; tag_in = t;
    stall = 1'b0; flush = 1'b0;
    if (push) q.push_back('{res, t, cyc + LAT});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      v_in = 1'b0; stall = 1'b0; flush = 1'b0;
    end
  endtask

  // v_i is held high with junk during a stall to show it is ignored
  task automatic stall_cycle();
    @(posedge clk); #1;
    v_in = 1'b1; fu_op = 5'd0; src1 = 64'hDEAD; src2 = 64'hBEEF; tag_in = 5'd31;
    stall = 1'b1; flush = 1'b0;
    foreach (q[i]) q[i].cyc++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ALU vectors: op, opw, src1, src2, result
    vecs.push_back('{5'd2,  1'b0, 64'hF0F0, 64'hFF00, 64'h0FF0});
    vecs.push_back('{5'd3,  1'b0, 64'hF0, 64'h0F, 64'hFF});
    vecs.push_back('{5'd4,  1'b0, 64'hF0F0, 64'hFF00, 64'hF000});
    vecs.push_back('{5'd5,  1'b0, 64'd1, 64'd63, 64'h8000000000000000});
    vecs.push_back('{5'd5,  1'b0, 64'd1, 64'd65, 64'd2});
    vecs.push_back('{5'd6,  1'b0, 64'h8000000000000000, 64'd4, 64'h0800000000000000});
    vecs.push_back('{5'd7,  1'b0, 64'h8000000000000000, 64'd4, 64'hF800000000000000});
    vecs.push_back('{5'd5,  1'b1, 64'd1, 64'd31, 64'hFFFFFFFF80000000});
    vecs.push_back('{5'd6,  1'b1, 64'hFFFFFFFF80000000, 64'd4, 64'h0000000008000000});
    vecs.push_back('{5'd7,  1'b1, 64'hFFFFFFFF80000000, 64'd4, 64'hFFFFFFFFF8000000});
    vecs.push_back('{5'd8,  1'b0, 64'd99, 64'h1234, 64'h1234});
    vecs.push_back('{5'd9,  1'b0, 64'd5, 64'd5, 64'd1});
    vecs.push_back('{5'd10, 1'b0, 64'd5, 64'd5, 64'd0});
    vecs.push_back('{5'd11, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd1, 64'd1});
    vecs.push_back('{5'd12, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd1, 64'd0});
    vecs.push_back('{5'd13, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd1, 64'd0});
    vecs.push_back('{5'd14, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd1, 64'd1});
    vecs.push_back('{5'd11, 1'b1, 64'h0000000080000000, 64'd0, 64'd1});
    vecs.push_back('{5'd11, 1'b0, 64'h0000000080000000, 64'd0, 64'd0});
    vecs.push_back('{5'd9,  1'b1, 64'h1_00000005, 64'h2_00000005, 64'd1});
    vecs.push_back('{5'd0,  1'b1, 64'h7FFFFFFF, 64'd1, 64'hFFFFFFFF80000000});
    vecs.push_back('{5'd1,  1'b0, 64'd0, 64'd1, 64'hFFFFFFFFFFFFFFFF});
    vecs.push_back('{5'd31, 1'b0, 64'd3, 64'd4, 64'd0});
`ifdef BP_BE_PIPE_INT_ZBB_EN
    vecs.push_back('{5'd20, 1'b0, 64'h0000000100000000, 64'd0, 64'd31});
    vecs.push_back('{5'd21, 1'b1, 64'd0, 64'd0, 64'd32});
    vecs.push_back('{5'd20, 1'b0, 64'd0, 64'd0, 64'd64});
    vecs.push_back('{5'd22, 1'b0, 64'hFF, 64'd0, 64'd8});
    vecs.push_back('{5'd16, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd1, 64'hFFFFFFFFFFFFFFFF});
    vecs.push_back('{5'd17, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd1, 64'd1});
    vecs.push_back('{5'd18, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd1, 64'd1});
    vecs.push_back('{5'd19, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd1, 64'hFFFFFFFFFFFFFFFF});
`else
    vecs.push_back('{5'd20, 1'b0, 64'h0000000100000000, 64'd0, 64'd0});
    vecs.push_back('{5'd16, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd1, 64'd0});
    vecs.push_back('{5'd22, 1'b0, 64'hFF, 64'd0, 64'd0});
`endif

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_v", {63'd0, v_out}, 64'd0);
    check("reset_data", data_out, 64'd0);
    check("reset_tag", {59'd0, tag_out}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Single add with latency check on either side of the result cycle
    issue(5'd0, 1'b0, 64'd5, 64'd7, 5'd3, 64'd12, 1'b1);
    idle(1);
    @(negedge clk);
    check("lat_early_v", {63'd0, v_out}, 64'd0);
    check("busy_inflight", {63'd0, busy}, 64'd1);
    idle(2);
    @(negedge clk);
    check("lat_after_v", {63'd0, v_out}, 64'd0);
    check("lat_after_data", data_out, 64'd0);
    idle(2);

    // Back-to-back ALU vectors
    for (int i = 0; i < vecs.size(); i++)
      issue(vecs[i].op, vecs[i].opw, vecs[i].s1, vecs[i].s2, 5'(i), vecs[i].res, 1'b1);
    idle(4);

    // Stall two cycles after the second of three issues
    issue(5'd0, 1'b0, 64'd10, 64'd1, 5'd1, 64'd11, 1'b1);
    issue(5'd0, 1'b0, 64'd20, 64'd2, 5'd2, 64'd22, 1'b1);
    stall_cycle();
    @(negedge clk);
    check("stall_hold_v", {63'd0, v_out}, 64'd1);
    check("stall_hold_tag", {59'd0, tag_out}, 64'd1);
    stall_cycle();
    issue(5'd0, 1'b0, 64'd30, 64'd3, 5'd3, 64'd33, 1'b1);
    idle(4);

    // Flush kills tags 4 and 5 in flight and drops tag 6 being issued
    issue(5'd0, 1'b0, 64'd40, 64'd4, 5'd4, 64'd44, 1'b0);
    issue(5'd0, 1'b0, 64'd50, 64'd5, 5'd5, 64'd55, 1'b0);
    @(negedge clk);
    check("busy_before_flush", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    v_in = 1'b1; tag_in = 5'd6; src1 = 64'd60; src2 = 64'd6; fu_op = 5'd0; flush = 1'b1;
    idle(1);
    @(negedge clk);
    check("flush_v", {63'd0, v_out}, 64'd0);
    check("flush_busy", {63'd0, busy}, 64'd0);
    idle(3);
    @(negedge clk);
    check("flush_busy_later", {63'd0, busy}, 64'd0);

    // Reset mid-stream while stalled, then a normal op afterwards
    issue(5'd0, 1'b0, 64'd70, 64'd7, 5'd7, 64'd77, 1'b0);
    issue(5'd0, 1'b0, 64'd80, 64'd8, 5'd8, 64'd88, 1'b0);
    @(posedge clk); #1;
    v_in = 1'b0; reset_n = 1'b0; stall = 1'b1; flush = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1; stall = 1'b0;
    @(negedge clk);
    check("midrst_v", {63'd0, v_out}, 64'd0);
    check("midrst_data", data_out, 64'd0);
    check("midrst_tag", {59'd0, tag_out}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    issue(5'd1, 1'b0, 64'd100, 64'd1, 5'd9, 64'd99, 1'b1);
    idle(5);

    check("queue_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bp_be_pipe_int_staged.md
Name: bp_be_pipe_int_staged

Overview:
- Parametrised successor to the single-cycle integer pipe. Computes RV64 integer ALU results, then carries them through a configurable number of register stages so the result arrives `latency_p` cycles after issue.
- Adds pipeline stall, flush of in-flight work, a destination tag that travels with each result, and an occupancy indication.
- Sits in the BE calculator alongside the other pipes and feeds writeback/bypass.

Parameters:
- dword_width_p, 64, full datapath width.
- word_width_p, 32, width for opw (W-suffix) operations; must be less than dword_width_p.
- latency_p, 2, register stages from issue to result; legal range 1..8.
- tag_width_p, 5, width of the destination tag passed through alongside the result.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  synchronous, active-low reset.
- v_i  in  1  issue valid.
- fu_op_i  in  5  operation encoding (see Behaviour).
- opw_i  in  1  word-width operation.
- src1_i  in  dword_width_p  operand 1 (rs1, or PC already selected upstream).
- src2_i  in  dword_width_p  operand 2 (rs2 or immediate).
- tag_i  in  tag_width_p  destination tag.
- stall_i  in  1  freeze all stages.
- flush_i  in  1  kill all in-flight operations.
- v_o  out  1  result valid.
- data_o  out  dword_width_p  result.
- tag_o  out  tag_width_p  tag belonging to data_o.
- busy_o  out  1  any stage holds a valid op.

Behaviour:
- Reset: while reset_n_i=0 at a clock edge, every stage valid/data/tag register clears. Consequently v_o=0, data_o=0, tag_o=0, busy_o=0. Reset overrides stall_i and flush_i.
- Op encoding:
  - 0 add, 1 sub, 2 xor, 3 or, 4 and.
  - 5 sll, 6 srl, 7 sra, 8 pass_src2.
  - 9 eq, 10 ne, 11 slt, 12 sltu, 13 sge, 14 sgeu.
  - 15–31 reserved; a reserved op produces result 0 with v_o still asserted.
- Compare ops return 0 or 1, zero-extended.
- Shift amount:
  - opw=0: src2[log2(dword_width_p)-1:0].
  - opw=1: src2[log2(word_width_p)-1:0].
- opw=1 arithmetic:
  - Operands are taken from their low word_width_p bits; sra/compares treat them as signed word values.
  - The result is the low word_width_p bits, sign-extended from bit word_width_p-1.
  - Compare results stay 0 or 1.
- Wrap-around: add/sub are modulo 2^width, with no overflow flag.
- Stage 0 (combinational result) is captured into stage 1 on the edge where v_i=1 and stall_i=0 and flush_i=0. Stage k moves to stage k+1 each unstalled cycle.
- Outputs come from the last stage register; latency is exactly latency_p cycles when no stall occurs.
- stall_i=1: every stage holds, v_i is ignored (upstream must re-present the op), and outputs stay constant.
- flush_i=1: all stage valid bits clear on that edge and the issuing op is dropped. Data/tag registers may keep stale values, but data_o and tag_o must be 0 whenever v_o=0. flush has priority over stall.
- Back-to-back issue is supported at one op per cycle; occupancy never exceeds latency_p.
- busy_o is the OR of all stage valids and is registered-derived, so it has no combinational path from v_i.
- data_o/tag_o are gated to 0 when v_o=0.

Optional Feature:
- Macro: BP_BE_PIPE_INT_ZBB_EN.
- When defined, these ops are enabled, all computed in stage 0:
  - 16 min, 17 max, 18 minu, 19 maxu.
  - 20 clz, 21 ctz, 22 cpop.
- With opw=1, clz/ctz/cpop count over the low word_width_p bits only. clz/ctz of zero return the operand width (64, or 32 for opw).
- When not defined, ops 16–22 behave as reserved and return 0 with v_o asserted.

Test Plan:
- latency_p=2, issue add src1=5, src2=7, tag=3, no stall → two cycles later v_o=1, data_o=12, tag_o=3; the following cycle v_o=0 and data_o=0.
- opw add src1=0x7FFFFFFF, src2=1 → data_o=0xFFFFFFFF80000000. Full-width sub 0−1 → 0xFFFFFFFFFFFFFFFF.
- Three back-to-back ops (tags 1,2,3) with stall_i=1 for 2 cycles after the second issue → outputs emerge in order 1,2,3 with no loss or duplication, the third delayed by 2 cycles.
- Issue ops tags 4 and 5, assert flush_i in the cycle tag 6 is presented → none of 4/5/6 ever appears on v_o, and busy_o=0 on the next cycle.
- Assert reset_n_i=0 mid-stream with stall_i=1 and flush_i=0 → all outputs 0 the next cycle; an op issued after reset deasserts returns normally.
- With the ZBB macro: clz of 0x0000_0001_0000_0000 → 31; opw ctz of 0 → 32; cpop of 0xFF → 8. Without the macro, op 20 → data_o=0 with v_o=1.
